// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared audio constants and I2S transmitter types
package i2s_tx_pkg;

   localparam int AUDIO_SAMPLE_WIDTH = 20;
   localparam int I2S_SLOT_WIDTH     = 32;
   localparam int I2S_BCLK_DIV       = 2;

   localparam int I2S_MODE_PHILIPS   = 1;
   localparam int I2S_MODE_LJ        = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } i2s_state_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit clock divider with single-clk rise/fall event strobes
module i2s_bclk_gen
   import i2s_tx_pkg::*;
#(
   parameter int BCLK_DIV = I2S_BCLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic bclk,
   output logic rise,
   output logic fall
);

   localparam int              DW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST = DW'(BCLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          tick;

   // Strobes flag the clk on whose edge bclk will toggle, so the shifter can move in lockstep.
   assign tick = run && (div_cnt == DIV_LAST);
   assign rise = tick && !bclk;
   assign fall = tick && bclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - stereo sample serializer for a 3-wire I2S / left-justified DAC link
module i2s_tx
   import i2s_tx_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
   parameter int BCLK_DIV     = I2S_BCLK_DIV,
   parameter int I2S_MODE     = I2S_MODE_PHILIPS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [SAMPLE_WIDTH-1:0] left,
   input  logic [SAMPLE_WIDTH-1:0] right,
   output logic                    sample_taken,
   output logic                    bclk,
   output logic                    lrck,
   output logic                    sdata
);

   localparam int             B_W     = $clog2(2 * SLOT_WIDTH);
   localparam logic [B_W-1:0] B_SLOT  = B_W'(SLOT_WIDTH);
   localparam logic [B_W-1:0] B_LAST  = B_W'(2 * SLOT_WIDTH - 1);
   localparam bit             PHILIPS = (I2S_MODE != I2S_MODE_LJ);

   i2s_state_e              state, state_nxt;
   logic [B_W-1:0]          b, b_nxt;
   logic [SAMPLE_WIDTH-1:0] shadow_l, shadow_r;
   logic                    run, rise, fall;

   // Philips mode delays the data by one bclk, so b=0 carries the wrapped padding slot.
   function automatic logic bit_at(input logic [B_W-1:0] idx,
                                   input logic [SAMPLE_WIDTH-1:0] l,
                                   input logic [SAMPLE_WIDTH-1:0] r);
      int unsigned             k, j;
      logic [SAMPLE_WIDTH-1:0] ch;
      k = 32'(idx);
      if (PHILIPS) k = (k == 0) ? 2 * SLOT_WIDTH - 1 : k - 1;
      ch = (k < SLOT_WIDTH) ? l : r;
      j  = (k < SLOT_WIDTH) ? k : k - SLOT_WIDTH;
      ch = ch << j;
      return (j < SAMPLE_WIDTH) ? ch[SAMPLE_WIDTH-1] : 1'b0;
   endfunction

   assign run   = (state == ST_RUN) && en;
   assign b_nxt = (b == B_LAST) ? '0 : b + 1'b1;

   i2s_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .bclk  (bclk),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (en)  state_nxt = ST_RUN;
         ST_RUN:  if (!en) state_nxt = ST_IDLE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b            <= '0;
         lrck         <= 1'b0;
         sdata        <= 1'b0;
         sample_taken <= 1'b0;
         shadow_l     <= '0;
         shadow_r     <= '0;
      end else begin
         sample_taken <= 1'b0;
         if (!en) begin
            b     <= '0;
            lrck  <= 1'b0;
            sdata <= 1'b0;
         end else if (state == ST_IDLE) begin
            shadow_l     <= left;
            shadow_r     <= right;
            sample_taken <= 1'b1;
            b            <= '0;
            lrck         <= 1'b0;
            sdata        <= bit_at('0, left, right);
         end else if (fall) begin
            b    <= b_nxt;
            lrck <= (b_nxt >= B_SLOT);
            // Frame wrap: both channels are captured together and bit 0 comes from the fresh pair.
            if (b_nxt == '0) begin
               shadow_l     <= left;
               shadow_r     <= right;
               sample_taken <= 1'b1;
               sdata        <= bit_at('0, left, right);
            end else begin
               sdata <= bit_at(b_nxt, shadow_l, shadow_r);
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n) rise |=> $stable(sdata));

endmodule
